// File: rtl/key_mode_sequencer.sv
// key_mode_sequencer
//   Front-end for the switch / 7-segment display datapath. Synchronizes the
//   slide switches and the active-low push-buttons, and debounces the buttons.
//   A small mode FSM selects how the operand is presented: original, ones'
//   complement or two's complement. Each accepted key press steps the FSM.
//   The transformed operand is registered for the hex display stage.
//
// Ports
//   clk       : system clock, all flops rising-edge
//   rst_n     : asynchronous active-low reset
//   key_n     : raw push-buttons, active-low, asynchronous, bouncy
//   sw        : raw slide switches, asynchronous
//   mode      : current mode (00 ORIG, 01 ONES, 10 TWOS)
//   data_out  : registered transformed operand
//   data_upd  : one-cycle pulse when data_out changed value
//   press_evt : one-cycle pulse per key on an accepted press (debounced 1->0)

module key_mode_sequencer #(
   parameter int unsigned W               = 10,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   key_n,
   input  logic [W-1:0] sw,
   output logic [1:0]   mode,
   output logic [W-1:0] data_out,
   output logic         data_upd,
   output logic [1:0]   press_evt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ORIG = 2'b00,
      ONES = 2'b01,
      TWOS = 2'b10
   } mode_t;

   mode_t              state;

   logic [1:0]         key_s1;
   logic [1:0]         key_s2;
   logic [W-1:0]       sw_s1;
   logic [W-1:0]       sw_s;

   logic [1:0]         db;
   logic [1:0]         db_q;
   logic [CNT_W-1:0]   cnt [2];

   logic [W-1:0]       data_nxt;

   // Two-flop synchronizers. Keys idle high (released), switches idle low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1 <= '1;
         key_s2 <= '1;
         sw_s1  <= '0;
         sw_s   <= '0;
      end else begin
         key_s1 <= key_n;
         key_s2 <= key_s1;
         sw_s1  <= sw;
         sw_s   <= sw_s1;
      end
   end

   // Debounce: a key level change is accepted only after DEBOUNCE_CYCLES
   // consecutive cycles of the new synced level; any reversion restarts.
   // db_q is the previous debounced level, so press_evt fires one cycle
   // after the debounced level falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db        <= '1;
         db_q      <= '1;
         cnt[0]    <= '0;
         cnt[1]    <= '0;
         press_evt <= '0;
      end else begin
         db_q      <= db;
         press_evt <= db_q & ~db;
         for (int unsigned i = 0; i < 2; i++) begin
            if (key_s2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= key_s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Mode FSM. Simultaneous presses force ORIG; a key whose mode is already
   // selected toggles back to ORIG.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ORIG;
      end else begin
         unique case (press_evt)
            2'b11:   state <= ORIG;
            2'b01:   state <= (state == ONES) ? ORIG : ONES;
            2'b10:   state <= (state == TWOS) ? ORIG : TWOS;
            default: state <= state;
         endcase
      end
   end

   assign mode = state;

   always_comb begin
      data_nxt = sw_s;
      unique case (state)
         ORIG:    data_nxt = sw_s;
         ONES:    data_nxt = ~sw_s;
         TWOS:    data_nxt = ~sw_s + W'(1);
         default: data_nxt = sw_s;
      endcase
   end

   // data_upd compares against the value being replaced, so a mode change
   // that yields the same operand produces no pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
         data_upd <= 1'b0;
      end else begin
         data_out <= data_nxt;
         data_upd <= (data_nxt != data_out);
      end
   end

endmodule
